// File: rtl/register_bank.sv
// Register bank with load strobes, an auto-incrementing index register, and carry/zero flag capture.
// Also holds a buffered output FIFO drained over valid/ready. INDEX_REG < NREGS; OUTDEPTH is a power of two >= 2.
module register_bank #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 4,
    parameter int INDEX_REG = 2,
    parameter int OUTDEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         resetB,
    input  logic [NREGS-1:0]             load,
    input  logic [WIDTH-1:0]             dbus,
    input  logic                         indexInc,
    input  logic                         captureFlags,
    input  logic                         carryIn,
    input  logic                         doOut,
    input  logic                         outReady,
    output logic [NREGS*WIDTH-1:0]       regs,
    output logic                         flagCarry,
    output logic                         flagZero,
    output logic                         outValid,
    output logic [WIDTH-1:0]             outData,
    output logic [$clog2(OUTDEPTH):0]    outCount,
    output logic                         outOverflow
);

    localparam int PW = $clog2(OUTDEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] reg_q [NREGS];
    logic [WIDTH-1:0] fifo_mem [OUTDEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             do_push;
    logic             do_pop;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            // A load on the index register takes priority over the increment.
            for (int i = 0; i < NREGS; i++) begin
                if (load[i]) begin
                    reg_q[i] <= dbus;
                end else if (i == INDEX_REG && indexInc) begin
                    reg_q[i] <= reg_q[i] + WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs[g*WIDTH +: WIDTH] = reg_q[g];
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            flagCarry <= 1'b0;
            flagZero  <= 1'b0;
        end else if (captureFlags) begin
            flagCarry <= carryIn;
            flagZero  <= (dbus == '0);
        end
    end

    assign fifo_full = (count == CW'(OUTDEPTH));
    assign outValid  = (count != '0);
    assign do_pop    = outValid && outReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = doOut && (!fifo_full || do_pop);

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            for (int i = 0; i < OUTDEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outOverflow <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= dbus;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (doOut && !do_push) begin
                outOverflow <= 1'b1;
            end
        end
    end

    assign outData  = fifo_mem[rd_ptr];
    assign outCount = count;

endmodule

// File: tb/tb_register_bank.sv
// Directed test-plan sequences followed by randomized traffic, all checked against a queue-based reference model.
module tb_register_bank;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 4;
    localparam int XI = 2;

    logic           clk = 1'b0;
    logic           resetB;
    logic [N-1:0]   load;
    logic [W-1:0]   dbus;
    logic           indexInc, captureFlags, carryIn, doOut, outReady;
    logic [N*W-1:0] regs;
    logic           flagCarry, flagZero, outValid, outOverflow;
    logic [W-1:0]   outData;
    logic [2:0]     outCount;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(W), .NREGS(N), .INDEX_REG(XI), .OUTDEPTH(D)) dut (
        .clk(clk), .resetB(resetB), .load(load), .dbus(dbus), .indexInc(indexInc),
        .captureFlags(captureFlags), .carryIn(carryIn), .doOut(doOut), .outReady(outReady),
        .regs(regs), .flagCarry(flagCarry), .flagZero(flagZero), .outValid(outValid),
        .outData(outData), .outCount(outCount), .outOverflow(outOverflow)
    );

    int checks = 0;
    int errors = 0;

    int         m_regs [N];
    bit         m_c, m_z, m_ovf;
    int         m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        load = '0; dbus = '0; indexInc = 0; captureFlags = 0;
        carryIn = 0; doOut = 0; outReady = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        m_c = 0; m_z = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_update();
        bit was_full, popping;
        was_full = (m_q.size() == D);
        popping  = (m_q.size() != 0) && outReady;
        for (int i = 0; i < N; i++) begin
            if (load[i]) m_regs[i] = int'(dbus);
            else if (i == XI && indexInc) m_regs[i] = (m_regs[i] + 1) % 256;
        end
        if (captureFlags) begin
            m_c = carryIn;
            m_z = (dbus == 0);
        end
        if (popping) void'(m_q.pop_front());
        if (doOut) begin
            if (!was_full || popping) m_q.push_back(int'(dbus));
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(regs[i*W +: W]), 32'(m_regs[i]));
        chk({tag, "_carry"}, 32'(flagCarry), 32'(m_c));
        chk({tag, "_zero"}, 32'(flagZero), 32'(m_z));
        chk({tag, "_valid"}, 32'(outValid), 32'(m_q.size() != 0));
        chk({tag, "_count"}, 32'(outCount), 32'(m_q.size()));
        chk({tag, "_ovf"}, 32'(outOverflow), 32'(m_ovf));
        if (m_q.size() != 0) chk({tag, "_data"}, 32'(outData), 32'(m_q[0]));
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        compare_all(tag);
        idle_inputs();
    endtask

    // Called 1 time unit after a rising edge, so the whole pulse sits between edges.
    task automatic pulse_reset(input string tag);
        resetB = 0;
        #2;
        chk({tag, "_rst_valid"}, 32'(outValid), 32'd0);
        chk({tag, "_rst_count"}, 32'(outCount), 32'd0);
        chk({tag, "_rst_x"}, 32'(regs[XI*W +: W]), 32'd0);
        chk({tag, "_rst_data"}, 32'(outData), 32'd0);
        chk({tag, "_rst_ovf"}, 32'(outOverflow), 32'd0);
        model_reset();
        #1;
        resetB = 1;
    endtask

    task automatic push(input logic [7:0] v, input logic rdy);
        doOut = 1; dbus = v; outReady = rdy;
        step("push");
    endtask

    task automatic drain_expect(input logic [7:0] v);
        chk("drain_head", 32'(outData), 32'(v));
        outReady = 1;
        step("drain");
    endtask

    initial begin
        idle_inputs();
        model_reset();
        resetB = 0;
        #2;
        chk("por_data", 32'(outData), 32'd0);
        #10;
        resetB = 1;
        #4;
        compare_all("por");

        @(posedge clk); #1;
        load = 4'b0011; dbus = 8'h5A; step("ld1");
        load = 4'b0100; dbus = 8'h07; step("ld2");
        chk("plan_A", 32'(regs[7:0]), 32'h5A);
        chk("plan_B", 32'(regs[15:8]), 32'h5A);
        chk("plan_X", 32'(regs[23:16]), 32'h07);
        chk("plan_R3", 32'(regs[31:24]), 32'h00);
        chk("plan_flags", 32'({flagCarry, flagZero, outOverflow}), 32'd0);

        load = 4'b0100; dbus = 8'hFE; step("xfe");
        indexInc = 1; step("inc1");
        chk("x_ff", 32'(regs[23:16]), 32'hFF);
        indexInc = 1; step("inc2");
        chk("x_wrap", 32'(regs[23:16]), 32'h00);
        indexInc = 1; load = 4'b0100; dbus = 8'h10; step("incld");
        chk("x_prio", 32'(regs[23:16]), 32'h10);

        captureFlags = 1; carryIn = 1; dbus = 8'h00; step("cap1");
        chk("cz_set", 32'({flagCarry, flagZero}), 32'b11);
        step("idle1");
        step("idle2");
        chk("cz_hold", 32'({flagCarry, flagZero}), 32'b11);
        captureFlags = 1; carryIn = 0; dbus = 8'h01; step("cap2");
        chk("cz_clr", 32'({flagCarry, flagZero}), 32'b00);

        for (int k = 1; k <= 5; k++) push(8'(k), 1'b0);
        chk("fill_count", 32'(outCount), 32'd4);
        chk("fill_ovf", 32'(outOverflow), 32'd1);
        for (int k = 1; k <= 4; k++) drain_expect(8'(k));
        chk("drained_valid", 32'(outValid), 32'd0);

        pulse_reset("r1");
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) push(8'(k), 1'b0);
        push(8'hAA, 1'b1);
        chk("pp_count", 32'(outCount), 32'd4);
        chk("pp_ovf", 32'(outOverflow), 32'd0);
        drain_expect(8'h02);
        drain_expect(8'h03);
        drain_expect(8'h04);
        drain_expect(8'hAA);
        chk("pp_empty", 32'(outValid), 32'd0);

        // Empty FIFO, push with ready high: accepted, nothing popped.
        push(8'h77, 1'b1);
        chk("empty_pushpop_count", 32'(outCount), 32'd1);
        drain_expect(8'h77);

        for (int k = 0; k < 3; k++) push(8'(8'h40 + k), 1'b0);
        load = 4'b0100; dbus = 8'h33; step("x33");
        pulse_reset("r2");
        @(posedge clk); #1;
        compare_all("post_r2");

        for (int n = 0; n < 3000; n++) begin
            load         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            dbus         = ($urandom_range(0, 7) == 0) ? 8'h00 :
                           ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            indexInc     = 1'($urandom);
            captureFlags = 1'($urandom);
            carryIn      = 1'($urandom);
            doOut        = ($urandom_range(0, 9) < 6);
            outReady     = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 3 : 8));
            step("rnd");
            if ($urandom_range(0, 399) == 0) pulse_reset("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
